// File: rtl/axis_join.sv
// Lock-step join of N AXI-Stream inputs through per-input FWFT FIFOs.
// One output beat pops the head of every FIFO; lasts are cross-checked per beat.
module axis_join #(
   parameter int unsigned N         = 2,
   parameter int unsigned W         = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LAST_MODE = 0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [N-1:0]        s_valid,
   output logic [N-1:0]        s_ready,
   input  logic [N-1:0]        s_last,
   input  logic [N-1:0][W-1:0] s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic [N-1:0][W-1:0] m_data,
   output logic                m_err,
   output logic                err_sticky,
   input  logic                err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic         r_en;
   logic         r_err_sticky;
   logic [N-1:0] w_nempty;
   logic [N-1:0] w_full;
   logic [N-1:0] w_push;
   logic [N-1:0] w_head_last;
   logic         w_pop;
   logic         w_all_last;
   logic         w_any_last;
   logic         w_err_set;

   // r_en keeps s_ready low through reset and drives it purely from flops.
   assign s_ready    = {N{r_en}} & ~w_full;
   assign w_push     = s_valid & s_ready;
   assign m_valid    = &w_nempty;
   assign w_pop      = m_valid & m_ready;
   assign w_all_last = &w_head_last;
   assign w_any_last = |w_head_last;
   assign m_last     = m_valid & ((LAST_MODE != 0) ? w_any_last : w_all_last);
   assign m_err      = m_valid & (w_all_last != w_any_last);
   assign w_err_set  = w_pop & m_err;
   assign err_sticky = r_err_sticky;

   for (genvar gi = 0; gi < N; gi++) begin : g_fifo
      logic [W:0]    r_mem [DEPTH];
      logic [AW-1:0] r_wptr;
      logic [AW-1:0] r_rptr;
      logic [CW-1:0] r_cnt;
      logic [W:0]    w_head;

      assign w_head          = r_mem[r_rptr];
      assign m_data[gi]      = w_head[W-1:0];
      assign w_head_last[gi] = w_head[W];
      assign w_nempty[gi]    = (r_cnt != '0);
      assign w_full[gi]      = (r_cnt == CW'(DEPTH));

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
               r_mem[j] <= '0;
            end
         end else begin
            if (w_push[gi]) begin
               r_mem[r_wptr] <= {s_last[gi], s_data[gi]};
               r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + AW'(1);
            end
            if (w_push[gi] && !w_pop) begin
               r_cnt <= r_cnt + CW'(1);
            end else if (!w_push[gi] && w_pop) begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_en         <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_en <= 1'b1;
         // A setting event beats a same-cycle clear.
         if (w_err_set) begin
            r_err_sticky <= 1'b1;
         end else if (err_clr) begin
            r_err_sticky <= 1'b0;
         end
      end
   end

endmodule
